hazard_ctrl: RTL

Parametrised ID-stage hazard controller for the 5-stage MIPS pipeline, sitting beside the IF/ID register and driving PC write-enable, IF/ID write-enable, control-bubble select and IF flush. It generalises load-use detection to a configurable load-to-use latency using a shift-register scoreboard of in-flight loads. It adds stalls for branches whose operands are still in flight, resolves six branch types plus jumps, and keeps saturating stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 57 +++++
 rtl/hazard_scoreboard.sv | 52 +++++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the ID-stage hazard controller.
//   - MIPS opcodes recognised by the controller (branches and jumps)
//   - REGIMM rt sub-codes (bltz / bgez)
//   - scoreboard entry layout and the branch-kind encoding
//   - decode_branch(): opcode/rt -> branch kind
package hazard_pkg;

  localparam logic [5:0] OPC_REGIMM = 6'b000001;
  localparam logic [5:0] OPC_J      = 6'b000010;
  localparam logic [5:0] OPC_JAL    = 6'b000011;
  localparam logic [5:0] OPC_BEQ    = 6'b000100;
  localparam logic [5:0] OPC_BNE    = 6'b000101;
  localparam logic [5:0] OPC_BLEZ   = 6'b000110;
  localparam logic [5:0] OPC_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  localparam int SB_REG_W = 5;

  typedef struct packed {
    logic                v;
    logic [SB_REG_W-1:0] rd;
  } sb_entry_t;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_BLEZ,
    BR_BGTZ,
    BR_BLTZ,
    BR_BGEZ
  } br_kind_t;

  // REGIMM with an rt code other than bltz/bgez is not treated as a branch,
  // so it can neither stall as a branch nor flush.
  function automatic br_kind_t decode_branch(input logic [5:0] opc,
                                             input logic       rt_is_bltz,
                                             input logic       rt_is_bgez);
    br_kind_t k;
    k = BR_NONE;
    case (opc)
      OPC_BEQ:    k = BR_BEQ;
      OPC_BNE:    k = BR_BNE;
      OPC_BLEZ:   k = BR_BLEZ;
      OPC_BGTZ:   k = BR_BGTZ;
      OPC_REGIMM: begin
        if (rt_is_bltz)      k = BR_BLTZ;
        else if (rt_is_bgez) k = BR_BGEZ;
      end
      default:    k = BR_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: LOAD_LAT-deep shift register of in-flight loads.
// Entry 0 captures the load leaving EX on each edge; older entries age by one
// position per edge, unconditionally (stall cycles included).
// Ports:
//   clk, rst_n        clock / async active-low reset (clears valid bits)
//   ex_memread, ex_rd load in ID/EX and its destination
//   rs, rt            ID source register fields
//   src_rs, src_rt    which source fields are real reads
//   match             per-entry hit vector (bit k = entry k matches a source)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_memread,
  input  logic [REG_W-1:0]    ex_rd,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic                src_rs,
  input  logic                src_rt,
  output logic [LOAD_LAT-1:0] match
);

  logic [LOAD_LAT-1:0] sb_v;
  logic [REG_W-1:0]    sb_rd [LOAD_LAT];

  // Loads to $0 never create a dependence, so they enter as invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v <= '0;
    end else begin
      sb_v[0] <= ex_memread && (ex_rd != '0);
      for (int k = 1; k < LOAD_LAT; k++) sb_v[k] <= sb_v[k-1];
    end
  end

  always_ff @(posedge clk) begin
    sb_rd[0] <= ex_rd;
    for (int k = 1; k < LOAD_LAT; k++) sb_rd[k] <= sb_rd[k-1];
  end

  always_comb begin
    match = '0;
    for (int k = 0; k < LOAD_LAT; k++)
      match[k] = sb_v[k] && ((src_rs && (sb_rd[k] == rs)) ||
                             (src_rt && (sb_rd[k] == rt)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage hazard controller for a 5-stage MIPS pipeline.
// Detects load-use hazards over a configurable load latency, stalls branches
// whose operands are still being produced, resolves branches/jumps in ID and
// counts stall and flush cycles with saturating counters.
// Ports:
//   clk, rst_n               clock / async active-low reset
//   id_opc, id_rs, id_rt     IF/ID instruction fields
//   id_uses_rt               ID instruction reads rt
//   rd1, rd2                 register-file read data (rs, rt)
//   ex_memread, ex_regwrite  ID/EX instruction is a load / writes a register
//   ex_rd                    ID/EX destination register
//   pc_write, if_id_write    PC and IF/ID update enables
//   ctrl_en                  0 injects a zero-control bubble into ID/EX
//   if_flush                 squash IF/ID on the next edge
//   stall_cnt, flush_cnt     saturating performance counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        id_opc,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_W-1:0]  ex_rd,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              ctrl_en,
  output logic              if_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // An ALU consumer only waits on the youngest LOAD_LAT-1 scoreboard entries;
  // the oldest entry is already forwardable to EX. Empty for LOAD_LAT=1.
  localparam logic [LOAD_LAT-1:0] ALU_MASK = LOAD_LAT'((1 << (LOAD_LAT - 1)) - 1);

  function automatic logic branch_taken(input br_kind_t                 k,
                                        input logic signed [DATA_W-1:0] a,
                                        input logic signed [DATA_W-1:0] b);
    logic t;
    t = 1'b0;
    case (k)
      BR_BEQ:  t = (a == b);
      BR_BNE:  t = (a != b);
      BR_BLEZ: t = (a <= 0);
      BR_BGTZ: t = (a > 0);
      BR_BLTZ: t = (a < 0);
      BR_BGEZ: t = (a >= 0);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  br_kind_t            br_kind;
  logic                is_branch;
  logic                rs_only;
  logic                is_jump;
  logic                src_rs;
  logic                src_rt;
  logic [LOAD_LAT-1:0] sb_match;
  logic                ex_hit;
  logic                alu_hazard;
  logic                br_hazard;
  logic                stall;
  logic                taken;
  logic                flush;

  // ID decode: which fields are real sources, what kind of control transfer.
  always_comb begin
    br_kind   = decode_branch(id_opc,
                              id_rt == REG_W'(RT_BLTZ),
                              id_rt == REG_W'(RT_BGEZ));
    is_branch = (br_kind != BR_NONE);
    rs_only   = (br_kind == BR_BLEZ) || (br_kind == BR_BGTZ) ||
                (br_kind == BR_BLTZ) || (br_kind == BR_BGEZ);
    is_jump   = (id_opc == OPC_J) || (id_opc == OPC_JAL);
    src_rs    = (id_rs != '0);
    src_rt    = id_uses_rt && (id_rt != '0) && !rs_only;
  end

  hazard_scoreboard #(
    .REG_W   (REG_W),
    .LOAD_LAT(LOAD_LAT)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_memread(ex_memread),
    .ex_rd     (ex_rd),
    .rs        (id_rs),
    .rt        (id_rt),
    .src_rs    (src_rs),
    .src_rt    (src_rt),
    .match     (sb_match)
  );

  // Hazard combine: branches compare in ID, so they also wait on any ALU
  // producer in EX and on the oldest scoreboard entry.
  always_comb begin
    ex_hit     = (src_rs && (ex_rd == id_rs)) || (src_rt && (ex_rd == id_rt));
    alu_hazard = (ex_memread && ex_hit) || (|(sb_match & ALU_MASK));
    br_hazard  = is_branch && ((ex_regwrite && ex_hit) || (|sb_match));
    stall      = alu_hazard || br_hazard;
    taken      = is_branch && branch_taken(br_kind, $signed(rd1), $signed(rd2));
    flush      = !stall && (taken || is_jump);
  end

  // Enables are forced low for as long as reset is held.
  assign pc_write    = rst_n && !stall;
  assign if_id_write = rst_n && !stall;
  assign ctrl_en     = rst_n && !stall;
  assign if_flush    = rst_n && flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= sat_inc(stall_cnt);
      if (flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule
